// File: rtl/rv32e_pkg.sv
// Shared RV32E definitions used by the fetch front-end and the core.
package rv32e_pkg;

  localparam int XLEN       = 32;
  localparam int ILEN       = 32;
  localparam int INST_BYTES = 4;

  localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  // One prefetch queue entry: the word and the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  // Force an address onto an instruction word boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/rv32e_fetch_fifo.sv
// Synchronous first-word-fall-through queue for fetched {pc, inst} entries.
// Flush empties the queue and overrides push and pop in the same cycle.
module rv32e_fetch_fifo
  import rv32e_pkg::*;
#(
  parameter int WIDTH = XLEN + ILEN,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  // Qualify push/pop: never pop empty, never push into a full queue unless it drains.
  always_comb begin
    pop_ok_s  = 1'b0;
    push_ok_s = 1'b0;
    if (flush) begin
      pop_ok_s  = 1'b0;
      push_ok_s = 1'b0;
    end else begin
      pop_ok_s  = pop && (count_r != '0);
      push_ok_s = push && ((count_r != CNT_FULL) || pop_ok_s);
    end
  end

  // Storage array; cleared on reset so the head reads zero when idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (push_ok_s && !pop_ok_s) begin
        count_r <= count_r + CNT_ONE;
      end else if (!push_ok_s && pop_ok_s) begin
        count_r <= count_r - CNT_ONE;
      end
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/rv32e_fetch_unit.sv
// Instruction fetch front-end: issues sequential word reads, buffers
// responses with their PCs, and discards wrong-path words on redirect.
// Requests are credit limited so queued plus in-flight words never exceed
// DEPTH, which guarantees every accepted response has a free queue slot.
module rv32e_fetch_unit
  import rv32e_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [ILEN-1:0] mem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;

  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [SW-1:0]   CREDIT   = SW'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(INST_BYTES);

  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] rsp_pc_r;
  logic [CW-1:0]   inflight_r;
  logic [CW-1:0]   discard_r;

  logic [CW-1:0]   count_s;
  fetch_entry_t    head_s;
  fetch_entry_t    push_entry_s;
  logic            req_valid_s;
  logic            req_fire_s;
  logic            rsp_fire_s;
  logic            push_s;
  logic            pop_s;
  logic [CW-1:0]   inflight_nxt_s;
  logic [CW-1:0]   discard_nxt_s;

  // Request credit: queued words plus outstanding reads must stay below DEPTH.
  always_comb begin
    req_valid_s = 1'b0;
    if (!reset) begin
      req_valid_s = 1'b0;
    end else begin
      req_valid_s = ({1'b0, count_s} + {1'b0, inflight_r}) < CREDIT;
    end
  end

  assign req_fire_s = req_valid_s && mem_req_ready;
  assign rsp_fire_s = mem_rsp_valid && (inflight_r != '0);

  // In-flight count after this cycle's request and response.
  always_comb begin
    inflight_nxt_s = inflight_r;
    if (req_fire_s && !rsp_fire_s) begin
      inflight_nxt_s = inflight_r + CNT_ONE;
    end else if (!req_fire_s && rsp_fire_s) begin
      inflight_nxt_s = inflight_r - CNT_ONE;
    end else begin
      inflight_nxt_s = inflight_r;
    end
  end

  // Response routing: redirect marks every outstanding read as wrong-path,
  // otherwise drop while discards are pending, else push into the queue.
  always_comb begin
    push_s        = 1'b0;
    discard_nxt_s = discard_r;
    if (redirect_valid) begin
      push_s        = 1'b0;
      discard_nxt_s = inflight_nxt_s;
    end else if (rsp_fire_s) begin
      if (discard_r != '0) begin
        push_s        = 1'b0;
        discard_nxt_s = discard_r - CNT_ONE;
      end else begin
        push_s        = 1'b1;
        discard_nxt_s = discard_r;
      end
    end else begin
      push_s        = 1'b0;
      discard_nxt_s = discard_r;
    end
  end

  assign pop_s = inst_valid && inst_ready && !redirect_valid;

  assign push_entry_s = '{pc: rsp_pc_r, inst: mem_rsp_data};

  rv32e_fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .flush     (redirect_valid),
    .head_data (head_s),
    .count     (count_s)
  );

  // Fetch and response PC tracking; redirect overrides sequential advance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_r <= RESET_PC;
      rsp_pc_r   <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc_r <= align_pc(redirect_pc);
      rsp_pc_r   <= align_pc(redirect_pc);
    end else begin
      if (req_fire_s) begin
        fetch_pc_r <= fetch_pc_r + PC_STEP;
      end
      if (push_s) begin
        rsp_pc_r <= rsp_pc_r + PC_STEP;
      end
    end
  end

  // Outstanding-read and wrong-path discard counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      inflight_r <= '0;
      discard_r  <= '0;
    end else begin
      inflight_r <= inflight_nxt_s;
      discard_r  <= discard_nxt_s;
    end
  end

  assign mem_req_valid = req_valid_s;
  assign mem_req_addr  = fetch_pc_r;
  assign inst_valid    = (count_s != '0);
  assign inst_data     = head_s.inst;
  assign inst_pc       = head_s.pc;

endmodule
